// File: rtl/capture_sequencer.sv
// Capture/readout sequencer for the 4-channel frame + histogram datapath.
// Optional idle-sample timeout in COLLECT is enabled by defining CAPSEQ_TIMEOUT_EN.
module capture_sequencer #(
   parameter int DATA_SIZE      = 4,
   parameter int DATA_NUM       = 16,
   parameter int LENGTH         = 64,
   parameter int LENGTH_SIZE    = 6,
   parameter int SETTLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     abort,
   input  logic                     sample_valid,
   input  logic                     out_ready,
   output logic                     collect,
   output logic                     frame_rd,
   output logic [LENGTH_SIZE-3:0]   frame_rd_addr,
   output logic [1:0]               frame_sel,
   output logic                     hist_rd,
   output logic [DATA_SIZE-1:0]     hist_rd_addr,
   output logic                     busy,
   output logic                     done,
   output logic [LENGTH_SIZE:0]     sample_count,
   output logic                     start_err,
   output logic                     timeout
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_COLLECT = 3'd1,
      S_SETTLE  = 3'd2,
      S_READ    = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   // One wait counter serves both the settle delay and the idle-sample timeout.
   localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0]          SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
   localparam logic [LENGTH_SIZE-1:0] RD_LAST     = LENGTH_SIZE'(LENGTH - 1);
   localparam logic [LENGTH_SIZE:0]   SMP_LAST    = (LENGTH_SIZE + 1)'(LENGTH - 1);
   localparam logic [LENGTH_SIZE:0]   HIST_END    = (LENGTH_SIZE + 1)'(DATA_NUM);
`ifdef CAPSEQ_TIMEOUT_EN
   localparam logic [CW-1:0]          TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
`endif

   state_t                 state_q, state_d;
   logic [LENGTH_SIZE-1:0] rd_idx_q, rd_idx_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [LENGTH_SIZE:0]   sample_count_q, sample_count_d;
   logic                   collect_q, collect_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   start_err_q, start_err_d;
   logic                   timeout_q, timeout_d;

   // State and status registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= S_IDLE;
         rd_idx_q       <= '0;
         cnt_q          <= '0;
         sample_count_q <= '0;
         collect_q      <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         start_err_q    <= 1'b0;
         timeout_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         rd_idx_q       <= rd_idx_d;
         cnt_q          <= cnt_d;
         sample_count_q <= sample_count_d;
         collect_q      <= collect_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         start_err_q    <= start_err_d;
         timeout_q      <= timeout_d;
      end
   end

   // Next-state, counters and registered status outputs.
   always_comb begin
      state_d        = state_q;
      rd_idx_d       = rd_idx_q;
      cnt_d          = cnt_q;
      sample_count_d = sample_count_q;
      start_err_d    = start_err_q;
      timeout_d      = timeout_q;

      if (start && (state_q != S_IDLE)) begin
         start_err_d = 1'b1;
      end else begin
         start_err_d = start_err_q;
      end

      if (abort) begin
         state_d  = S_IDLE;
         rd_idx_d = '0;
         cnt_d    = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d        = S_COLLECT;
                  sample_count_d = '0;
                  start_err_d    = 1'b0;
                  timeout_d      = 1'b0;
                  cnt_d          = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_COLLECT: begin
               if (sample_valid) begin
                  sample_count_d = sample_count_q + (LENGTH_SIZE + 1)'(1);
                  cnt_d          = '0;
                  if (sample_count_q == SMP_LAST) begin
                     state_d = S_SETTLE;
                  end else begin
                     state_d = S_COLLECT;
                  end
`ifdef CAPSEQ_TIMEOUT_EN
               end else if (cnt_q == TIMEOUT_LAST) begin
                  state_d   = S_SETTLE;
                  cnt_d     = '0;
                  timeout_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
`else
               end else begin
                  state_d = S_COLLECT;
               end
`endif
            end
            S_SETTLE: begin
               if (cnt_q == SETTLE_LAST) begin
                  state_d  = S_READ;
                  rd_idx_d = '0;
                  cnt_d    = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            S_READ: begin
               if (out_ready) begin
                  if (rd_idx_q == RD_LAST) begin
                     state_d  = S_DONE;
                     rd_idx_d = '0;
                  end else begin
                     rd_idx_d = rd_idx_q + LENGTH_SIZE'(1);
                  end
               end else begin
                  state_d = S_READ;
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end

      collect_d = (state_d == S_COLLECT);
      busy_d    = (state_d != S_IDLE);
      done_d    = (state_d == S_DONE);
   end

   // Read strobes follow out_ready directly so a stalled beat never issues a read.
   always_comb begin
      frame_rd      = 1'b0;
      frame_rd_addr = '0;
      frame_sel     = 2'b00;
      hist_rd       = 1'b0;
      hist_rd_addr  = '0;
      if (state_q == S_READ) begin
         frame_rd      = out_ready;
         frame_rd_addr = rd_idx_q[LENGTH_SIZE-1:2];
         frame_sel     = rd_idx_q[1:0];
         if ({1'b0, rd_idx_q} < HIST_END) begin
            hist_rd      = out_ready;
            hist_rd_addr = rd_idx_q[DATA_SIZE-1:0];
         end else begin
            hist_rd      = 1'b0;
            hist_rd_addr = '0;
         end
      end else begin
         frame_rd = 1'b0;
      end
   end

   assign collect      = collect_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign sample_count = sample_count_q;
   assign start_err    = start_err_q;
   assign timeout      = timeout_q;

endmodule
